sys_addr_burst_router: RTL and testbench
========================================

# sys_addr_burst_router

Registered, burst-capable successor to the system address decoder. It accepts one host request (base word address, beat count, broadcast flag) over a valid/ready handshake. It then emits one decoded beat per cycle under downstream backpressure, auto-incrementing the address and routing each beat to one of: control regs, CP IMEM, PE IMEM, CP DMEM, or one, all, or no PE DMEM banks. It sits between the AXI-lite slave front end and the memory/control fabric. It supports PE counts that are not a power of two, and it flags beats that target a non-existent PE.

## Interface
- C_AWIDTH, 32, host address width and output address width
- C_EFF_AWIDTH, 20, decoded address bits; E below; must be ≥ C_PE_ID_WIDTH+6
- C_NUM_PE, 16, number of PE DMEM banks; 1..2^C_PE_ID_WIDTH
- C_PE_ID_WIDTH, 4, width of PE id field at iReqAddr[W+1:2]
- C_LEN_WIDTH, 8, width of beat count; burst length = iReqLen+1
- C_CTRL_AWIDTH, 10, control-register offset width
- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  asynchronous active-low reset
- iReqValid / oReqReady  in/out  1  request handshake
- iReqAddr  in  C_AWIDTH  base address; bits above E-1 ignored
- iReqLen  in  C_LEN_WIDTH  beats minus one
- iReqBcast  in  1  broadcast PE DMEM beats to all banks
- oBeatValid / iBeatReady  out/in  1  beat handshake
- oBeatLast  out  1  current beat is final
- oBeatIdx  out  C_LEN_WIDTH  beat index from 0
- oCtrlEn, oCPIMemEn, oPEIMemEn, oCPDMemEn  out  1  region enables
- oCtrlAddr, oCPIMemAddr, oPEIMemAddr, oCPDMemAddr, oPEDMemRowAddr  out  C_AWIDTH  zero-extended region addresses
- oPEDMemEn  out  C_NUM_PE  per-bank enable
- oBeatErr  out  1  current beat targets PE id ≥ C_NUM_PE
- oErrSticky  out  1  latched error; iErrClr  in  1  clears it

## Operation
- FSM states:
  - IDLE: oReqReady=1. iReqValid moves to BURST, latching addr[E-1:0], len and bcast, and setting beat counter to 0.
  - BURST: oReqReady=0, oBeatValid=1.
- On iBeatReady in BURST: if the beat is the last one (counter==len), go to IDLE; else counter+1 and address+1, modulo 2^E (wraps 0xFFFFF→0x00000 at E=20).
- Decode is combinational on the registered beat address a. All outputs come from registers or that decode only; no path from request inputs to beat outputs.
  - PE DMEM: when a[E-1]|a[E-2]. Id = a[W+1:2]. Row = {a[E-1:E-2]-1, a[E-3:W+2], a[1:0]}, width E-W.
  - Ctrl: when not PE and &a[E-3:C_CTRL_AWIDTH]. Address = a[C_CTRL_AWIDTH-1:0].
  - IMEM: when not PE, not ctrl, and ~a[E-3]. a[E-4]=0 selects CP, a[E-4]=1 selects PE. Address = a[E-5:0].
  - CP DMEM: otherwise. Address = a[E-4:0].
- PE DMEM enable:
  - bcast=1: all C_NUM_PE bits set; no error.
  - bcast=0, id<C_NUM_PE: one-hot bit id.
  - bcast=0, id≥C_NUM_PE: all zero and oBeatErr=1. The beat still completes normally.
- bcast is ignored for non-PE beats.
- All enables and oBeatErr are gated by oBeatValid. Address outputs are don't-care when invalid but held stable.
- oErrSticky is set when oBeatValid & iBeatReady & oBeatErr. It is cleared by iErrClr; set wins over a simultaneous clear.

## Timing
- Reset (async assert): state IDLE, oReqReady=1, oBeatValid=0, all enables 0, oBeatLast=0, oBeatIdx=0, oBeatErr=0, oErrSticky=0, all address outputs 0.
- Reset mid-burst aborts the burst immediately; no further beats are emitted.
- A request accepted at edge N gives its first beat valid at cycle N+1.
- Throughput is one beat per cycle while iBeatReady=1. A length-L burst occupies L+1 cycles from accept to oReqReady=1 (oReqReady rises the cycle after the last beat is accepted).
- With iBeatReady=0, all beat outputs hold stable until accepted.
- No request overlap: oReqReady=0 throughout BURST.
- iReqLen at its maximum produces 2^C_LEN_WIDTH beats. oBeatIdx never wraps within a burst.

## Test plan
Parameters for all scenarios: E=20, W=4, C_NUM_PE=12.
- Single beats, len 0:
  - 0x00100 → oCPIMemEn, addr 0x100.
  - 0x10020 → oPEIMemEn, addr 0x020.
  - 0x20040 → oCPDMemEn, addr 0x040.
  - 0x3FC05 → oCtrlEn, addr 0x005.
  - 0x40015 → oPEDMemEn=0x020, row 0x0001.
- Burst at 0x4003E, len 3, iBeatReady=1:
  - Beats 0 and 1: PE id 15, enables 0, oBeatErr=1.
  - Beat 2: PE0, row 0x0004. Beat 3: PE0, row 0x0005, oBeatLast=1.
  - oErrSticky=1 after the burst; oReqReady=1 one cycle after beat 3.
- Broadcast at 0x80031 (id 12), len 0, bcast=1 → oPEDMemEn=0xFFF, row 0x4001, oBeatErr=0.
- Backpressure: burst at 0x00000, len 2, with iBeatReady toggling 0,0,1,0,1,1.
  - Each beat is held stable until accepted; exactly 3 beats with addrs 0,1,2.
  - No request is accepted until the burst finishes.
- Wrap: base 0xFFFFF, len 1 → beat 0 is PE DMEM id 15 (error); beat 1 is address 0x00000, CP IMEM.
- Error and reset:
  - iErrClr in the same cycle as an error beat is accepted → oErrSticky stays 1.
  - iRst low during beat 1 of a len 5 burst → outputs return to reset values asynchronously; oReqReady=1 after release.

Source files
------------

// File: rtl/sys_addr_burst_router.sv
// Burst-capable system address router: accepts one host request, then emits one
// registered, decoded beat per cycle with auto-incrementing address under backpressure.
module sys_addr_burst_router #(
  parameter int unsigned C_AWIDTH      = 32,
  parameter int unsigned C_EFF_AWIDTH  = 20,
  parameter int unsigned C_NUM_PE      = 16,
  parameter int unsigned C_PE_ID_WIDTH = 4,
  parameter int unsigned C_LEN_WIDTH   = 8,
  parameter int unsigned C_CTRL_AWIDTH = 10
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iReqValid,
  output logic                     oReqReady,
  input  logic [C_AWIDTH-1:0]      iReqAddr,
  input  logic [C_LEN_WIDTH-1:0]   iReqLen,
  input  logic                     iReqBcast,
  output logic                     oBeatValid,
  input  logic                     iBeatReady,
  output logic                     oBeatLast,
  output logic [C_LEN_WIDTH-1:0]   oBeatIdx,
  output logic                     oCtrlEn,
  output logic                     oCPIMemEn,
  output logic                     oPEIMemEn,
  output logic                     oCPDMemEn,
  output logic [C_AWIDTH-1:0]      oCtrlAddr,
  output logic [C_AWIDTH-1:0]      oCPIMemAddr,
  output logic [C_AWIDTH-1:0]      oPEIMemAddr,
  output logic [C_AWIDTH-1:0]      oCPDMemAddr,
  output logic [C_AWIDTH-1:0]      oPEDMemRowAddr,
  output logic [C_NUM_PE-1:0]      oPEDMemEn,
  output logic                     oBeatErr,
  output logic                     oErrSticky,
  input  logic                     iErrClr
);

  localparam int unsigned E  = C_EFF_AWIDTH;
  localparam int unsigned W  = C_PE_ID_WIDTH;
  localparam int unsigned RW = C_EFF_AWIDTH - C_PE_ID_WIDTH;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                 state_q, state_d;
  logic [E-1:0]           addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic                   bcast_q, bcast_d;
  logic [C_LEN_WIDTH-1:0] idx_q, idx_d;
  logic                   load;

  logic                   ctrl_en_q, ctrl_en_d;
  logic                   cp_imem_en_q, cp_imem_en_d;
  logic                   pe_imem_en_q, pe_imem_en_d;
  logic                   cp_dmem_en_q, cp_dmem_en_d;
  logic [C_NUM_PE-1:0]    pe_dmem_en_q, pe_dmem_en_d;
  logic                   beat_err_q, beat_err_d;
  logic                   beat_last_q, beat_last_d;
  logic                   err_sticky_q, err_sticky_d;
  logic [C_AWIDTH-1:0]    ctrl_addr_q, ctrl_addr_d;
  logic [C_AWIDTH-1:0]    cp_imem_addr_q, cp_imem_addr_d;
  logic [C_AWIDTH-1:0]    pe_imem_addr_q, pe_imem_addr_d;
  logic [C_AWIDTH-1:0]    cp_dmem_addr_q, cp_dmem_addr_d;
  logic [C_AWIDTH-1:0]    pe_row_q, pe_row_d;

  logic                   dec_pe, dec_ctrl, dec_imem, dec_cpi, dec_pei, dec_cpd, dec_hit;
  logic [W-1:0]           dec_id;
  logic [C_NUM_PE-1:0]    dec_pe_en;
  logic [RW-1:0]          dec_row;
  logic                   beat_valid_d;

  // Host address bits above the decoded window are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^iReqAddr[C_AWIDTH-1:E];

  // Request/beat sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    bcast_d = bcast_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          state_d = S_BURST;
          addr_d  = iReqAddr[E-1:0];
          len_d   = iReqLen;
          bcast_d = iReqBcast;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      S_BURST: begin
        if (iBeatReady) begin
          if (idx_q == len_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + C_LEN_WIDTH'(1);
            addr_d = addr_q + E'(1);
            load   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode the next beat address so every beat output is presented from a flop.
  always_comb begin
    beat_valid_d = (state_d == S_BURST);
    dec_pe    = addr_d[E-1] | addr_d[E-2];
    dec_id    = addr_d[W+1:2];
    dec_ctrl  = ~dec_pe & (&addr_d[E-3:C_CTRL_AWIDTH]);
    dec_imem  = ~dec_pe & ~dec_ctrl & ~addr_d[E-3];
    dec_cpi   = dec_imem & ~addr_d[E-4];
    dec_pei   = dec_imem & addr_d[E-4];
    dec_cpd   = ~dec_pe & ~dec_ctrl & addr_d[E-3];
    dec_hit   = 32'(dec_id) < C_NUM_PE;
    dec_row   = {addr_d[E-1:E-2] - 2'd1, addr_d[E-3:W+2], addr_d[1:0]};
    dec_pe_en = '0;
    if (bcast_d) begin
      dec_pe_en = {C_NUM_PE{1'b1}};
    end else if (dec_hit) begin
      dec_pe_en = C_NUM_PE'(1) << dec_id;
    end

    ctrl_en_d    = beat_valid_d & dec_ctrl;
    cp_imem_en_d = beat_valid_d & dec_cpi;
    pe_imem_en_d = beat_valid_d & dec_pei;
    cp_dmem_en_d = beat_valid_d & dec_cpd;
    pe_dmem_en_d = (beat_valid_d & dec_pe) ? dec_pe_en : '0;
    beat_err_d   = beat_valid_d & dec_pe & ~bcast_d & ~dec_hit;
    beat_last_d  = beat_valid_d & (idx_d == len_d);
    err_sticky_d = (oBeatValid & iBeatReady & beat_err_q) | (err_sticky_q & ~iErrClr);

    ctrl_addr_d    = ctrl_addr_q;
    cp_imem_addr_d = cp_imem_addr_q;
    pe_imem_addr_d = pe_imem_addr_q;
    cp_dmem_addr_d = cp_dmem_addr_q;
    pe_row_d       = pe_row_q;
    if (load) begin
      ctrl_addr_d    = C_AWIDTH'(addr_d[C_CTRL_AWIDTH-1:0]);
      cp_imem_addr_d = C_AWIDTH'(addr_d[E-5:0]);
      pe_imem_addr_d = C_AWIDTH'(addr_d[E-5:0]);
      cp_dmem_addr_d = C_AWIDTH'(addr_d[E-4:0]);
      pe_row_d       = C_AWIDTH'(dec_row);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      bcast_q        <= 1'b0;
      idx_q          <= '0;
      ctrl_en_q      <= 1'b0;
      cp_imem_en_q   <= 1'b0;
      pe_imem_en_q   <= 1'b0;
      cp_dmem_en_q   <= 1'b0;
      pe_dmem_en_q   <= '0;
      beat_err_q     <= 1'b0;
      beat_last_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
      ctrl_addr_q    <= '0;
      cp_imem_addr_q <= '0;
      pe_imem_addr_q <= '0;
      cp_dmem_addr_q <= '0;
      pe_row_q       <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      bcast_q        <= bcast_d;
      idx_q          <= idx_d;
      ctrl_en_q      <= ctrl_en_d;
      cp_imem_en_q   <= cp_imem_en_d;
      pe_imem_en_q   <= pe_imem_en_d;
      cp_dmem_en_q   <= cp_dmem_en_d;
      pe_dmem_en_q   <= pe_dmem_en_d;
      beat_err_q     <= beat_err_d;
      beat_last_q    <= beat_last_d;
      err_sticky_q   <= err_sticky_d;
      ctrl_addr_q    <= ctrl_addr_d;
      cp_imem_addr_q <= cp_imem_addr_d;
      pe_imem_addr_q <= pe_imem_addr_d;
      cp_dmem_addr_q <= cp_dmem_addr_d;
      pe_row_q       <= pe_row_d;
    end
  end

  assign oReqReady      = (state_q == S_IDLE);
  assign oBeatValid     = (state_q == S_BURST);
  assign oBeatLast      = beat_last_q;
  assign oBeatIdx       = idx_q;
  assign oCtrlEn        = ctrl_en_q;
  assign oCPIMemEn      = cp_imem_en_q;
  assign oPEIMemEn      = pe_imem_en_q;
  assign oCPDMemEn      = cp_dmem_en_q;
  assign oPEDMemEn      = pe_dmem_en_q;
  assign oBeatErr       = beat_err_q;
  assign oErrSticky     = err_sticky_q;
  assign oCtrlAddr      = ctrl_addr_q;
  assign oCPIMemAddr    = cp_imem_addr_q;
  assign oPEIMemAddr    = pe_imem_addr_q;
  assign oCPDMemAddr    = cp_dmem_addr_q;
  assign oPEDMemRowAddr = pe_row_q;

endmodule

// File: tb/tb_sys_addr_burst_router.sv
// Scoreboard bench for sys_addr_burst_router: directed requests push expected beats,
// a negedge monitor pops and compares every accepted beat and checks hold stability.
module tb_sys_addr_burst_router;

  logic        iClk, iRst;
  logic        iReqValid, oReqReady, iReqBcast;
  logic [31:0] iReqAddr;
  logic [7:0]  iReqLen, oBeatIdx;
  logic        oBeatValid, iBeatReady, oBeatLast;
  logic        oCtrlEn, oCPIMemEn, oPEIMemEn, oCPDMemEn;
  logic [31:0] oCtrlAddr, oCPIMemAddr, oPEIMemAddr, oCPDMemAddr, oPEDMemRowAddr;
  logic [11:0] oPEDMemEn;
  logic        oBeatErr, oErrSticky, iErrClr;

  sys_addr_burst_router #(
    .C_AWIDTH(32), .C_EFF_AWIDTH(20), .C_NUM_PE(12),
    .C_PE_ID_WIDTH(4), .C_LEN_WIDTH(8), .C_CTRL_AWIDTH(10)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqAddr(iReqAddr), .iReqLen(iReqLen), .iReqBcast(iReqBcast),
    .oBeatValid(oBeatValid), .iBeatReady(iBeatReady),
    .oBeatLast(oBeatLast), .oBeatIdx(oBeatIdx),
    .oCtrlEn(oCtrlEn), .oCPIMemEn(oCPIMemEn), .oPEIMemEn(oPEIMemEn), .oCPDMemEn(oCPDMemEn),
    .oCtrlAddr(oCtrlAddr), .oCPIMemAddr(oCPIMemAddr), .oPEIMemAddr(oPEIMemAddr),
    .oCPDMemAddr(oCPDMemAddr), .oPEDMemRowAddr(oPEDMemRowAddr),
    .oPEDMemEn(oPEDMemEn), .oBeatErr(oBeatErr),
    .oErrSticky(oErrSticky), .iErrClr(iErrClr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // rgn: 0 ctrl, 1 CP IMEM, 2 PE IMEM, 3 CP DMEM, 4 PE DMEM
  typedef struct packed {
    logic [2:0]  rgn;
    logic [11:0] pe;
    logic [31:0] addr;
    logic        err;
    logic        last;
    logic [7:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] rgn, input logic [11:0] pe, input logic [31:0] addr,
                      input logic err, input logic last, input logic [7:0] idx);
    exp_t e;
    e.rgn = rgn; e.pe = pe; e.addr = addr; e.err = err; e.last = last; e.idx = idx;
    exp_q.push_back(e);
  endtask

  function automatic logic [188:0] outs();
    return {oReqReady, oBeatValid, oCtrlEn, oCPIMemEn, oPEIMemEn, oCPDMemEn, oPEDMemEn,
            oBeatLast, oBeatIdx, oBeatErr, oErrSticky,
            oCtrlAddr, oCPIMemAddr, oPEIMemAddr, oCPDMemAddr, oPEDMemRowAddr};
  endfunction

  logic [188:0] rst_exp;
  initial begin
    rst_exp = '0;
    rst_exp[188] = 1'b1;
  end

  // Monitor: compare each accepted beat, and check held beats do not change.
  logic [185:0] held;
  bit           hold_pend = 0;
  wire  [185:0] snap = {oCtrlEn, oCPIMemEn, oPEIMemEn, oCPDMemEn, oPEDMemEn, oBeatErr,
                        oBeatLast, oBeatIdx, oCtrlAddr, oCPIMemAddr, oPEIMemAddr,
                        oCPDMemAddr, oPEDMemRowAddr};

  always @(negedge iClk) begin
    exp_t        e;
    logic [31:0] a;
    logic [57:0] act, expv;
    if (!iRst) begin
      hold_pend = 0;
    end else if (oBeatValid) begin
      if (hold_pend) chk("hold_stable", 256'(snap), 256'(held));
      if (iBeatReady) begin
        hold_pend = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got beat idx %0d, required none", oBeatIdx);
        end else begin
          e = exp_q.pop_front();
          case (e.rgn)
            3'd0:    a = oCtrlAddr;
            3'd1:    a = oCPIMemAddr;
            3'd2:    a = oPEIMemAddr;
            3'd3:    a = oCPDMemAddr;
            default: a = oPEDMemRowAddr;
          endcase
          act  = {oCtrlEn, oCPIMemEn, oPEIMemEn, oCPDMemEn, oPEDMemEn, oBeatErr, oBeatLast,
                  oBeatIdx, a};
          expv = {e.rgn == 3'd0, e.rgn == 3'd1, e.rgn == 3'd2, e.rgn == 3'd3, e.pe, e.err,
                  e.last, e.idx, e.addr};
          chk($sformatf("beat rgn%0d idx%0d", e.rgn, e.idx), 256'(act), 256'(expv));
        end
      end else begin
        hold_pend = 1;
        held = snap;
      end
    end
  end

  task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic b);
    int n = 0;
    while (!oReqReady && n < 200) begin
      @(posedge iClk); #1;
      n++;
    end
    if (!oReqReady) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got oReqReady=0, required 1");
    end
    iReqAddr = a; iReqLen = l; iReqBcast = b; iReqValid = 1'b1;
    @(posedge iClk); #1;
    iReqValid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !oReqReady) && n < 300) begin
      @(posedge iClk); #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0 || !oReqReady) begin
      bad++;
      $display("FAIL burst_timeout: got pending=%0d ready=%0b, required 0 and 1",
               exp_q.size(), oReqReady);
    end
  endtask

  task automatic clear_sticky();
    iErrClr = 1'b1;
    @(posedge iClk); #1;
    iErrClr = 1'b0;
    chk("sticky_cleared", 256'(oErrSticky), 256'(0));
  endtask

  initial begin
    logic [5:0] pat;
    iRst = 1'b0; iReqValid = 1'b0; iReqAddr = '0; iReqLen = '0; iReqBcast = 1'b0;
    iBeatReady = 1'b1; iErrClr = 1'b0;
    #12;
    chk("reset_state", 256'(outs()), 256'(rst_exp));
    @(negedge iClk); iRst = 1'b1;
    @(posedge iClk); #1;

    // Single beats; upper host bits on the first one must be ignored.
    push(3'd1, 12'h000, 32'h100, 1'b0, 1'b1, 8'd0);
    send_req(32'hA0000100, 8'd0, 1'b0); wait_done();
    push(3'd2, 12'h000, 32'h020, 1'b0, 1'b1, 8'd0);
    send_req(32'h00010020, 8'd0, 1'b0); wait_done();
    push(3'd3, 12'h000, 32'h040, 1'b0, 1'b1, 8'd0);
    send_req(32'h00020040, 8'd0, 1'b0); wait_done();
    push(3'd0, 12'h000, 32'h005, 1'b0, 1'b1, 8'd0);
    send_req(32'h0003FC05, 8'd0, 1'b0); wait_done();
    push(3'd4, 12'h020, 32'h0001, 1'b0, 1'b1, 8'd0);
    send_req(32'h00040015, 8'd0, 1'b0); wait_done();
    chk("sticky_idle", 256'(oErrSticky), 256'(0));

    // Burst through non-existent PE 15 into PE0.
    push(3'd4, 12'h000, 32'h0002, 1'b1, 1'b0, 8'd0);
    push(3'd4, 12'h000, 32'h0003, 1'b1, 1'b0, 8'd1);
    push(3'd4, 12'h001, 32'h0004, 1'b0, 1'b0, 8'd2);
    push(3'd4, 12'h001, 32'h0005, 1'b0, 1'b1, 8'd3);
    send_req(32'h0004003E, 8'd3, 1'b0);
    repeat (3) @(posedge iClk);
    #1;
    chk("ready_low_in_burst", 256'(oReqReady), 256'(0));
    @(posedge iClk); #1;
    chk("ready_after_burst", 256'(oReqReady), 256'(1));
    chk("sticky_after_err", 256'(oErrSticky), 256'(1));
    wait_done();
    clear_sticky();

    // Broadcast to id 12 is not an error.
    push(3'd4, 12'hFFF, 32'h4001, 1'b0, 1'b1, 8'd0);
    send_req(32'h00080031, 8'd0, 1'b1); wait_done();
    chk("sticky_bcast", 256'(oErrSticky), 256'(0));

    // Backpressure 0,0,1,0,1,1.
    iBeatReady = 1'b0;
    push(3'd1, 12'h000, 32'h0, 1'b0, 1'b0, 8'd0);
    push(3'd1, 12'h000, 32'h1, 1'b0, 1'b0, 8'd1);
    push(3'd1, 12'h000, 32'h2, 1'b0, 1'b1, 8'd2);
    send_req(32'h0, 8'd2, 1'b0);
    pat = 6'b110100;
    for (int i = 0; i < 6; i++) begin
      iBeatReady = pat[i];
      chk($sformatf("no_accept_bp%0d", i), 256'(oReqReady), 256'(0));
      @(posedge iClk); #1;
    end
    chk("ready_after_bp", 256'(oReqReady), 256'(1));
    iBeatReady = 1'b1;
    wait_done();

    // Address wrap at top of the decoded window.
    push(3'd4, 12'h000, 32'hBFFF, 1'b1, 1'b0, 8'd0);
    push(3'd1, 12'h000, 32'h0, 1'b0, 1'b1, 8'd1);
    send_req(32'h000FFFFF, 8'd1, 1'b0); wait_done();
    clear_sticky();

    // Set wins over simultaneous clear.
    push(3'd4, 12'h000, 32'h0002, 1'b1, 1'b1, 8'd0);
    iErrClr = 1'b1;
    send_req(32'h0004003E, 8'd0, 1'b0);
    @(posedge iClk); #1;
    chk("sticky_set_wins", 256'(oErrSticky), 256'(1));
    iErrClr = 1'b0;
    wait_done();
    chk("sticky_holds", 256'(oErrSticky), 256'(1));

    // Asynchronous reset during beat 1 of a len-5 burst.
    push(3'd1, 12'h000, 32'h0, 1'b0, 1'b0, 8'd0);
    send_req(32'h0, 8'd5, 1'b0);
    @(posedge iClk); #2;
    iRst = 1'b0;
    #1;
    chk("reset_mid_burst", 256'(outs()), 256'(rst_exp));
    chk("queue_after_reset", 256'(exp_q.size()), 256'(0));
    @(negedge iClk); iRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge iClk); #1;
      chk($sformatf("idle_after_reset%0d", i), 256'({oReqReady, oBeatValid}), 256'(2'b10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
